// File: rtl/starter_frame_rx.sv
// starter_frame_rx: parses SOF/LEN/payload/CSUM frames from a byte stream,
// buffers payload in a FIFO and releases it only once the checksum verifies.
module starter_frame_rx #(
    parameter int         DEPTH   = 16,
    parameter int         MAX_LEN = 16,
    parameter logic [7:0] SOF     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [7:0] err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CSUM
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] commit_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] used;
    logic [PW-1:0] free_space;
    logic [8:0]    mem [DEPTH];
    logic [8:0]    head;
    logic [7:0]    csum_acc;
    logic [7:0]    rem;
    logic          len_bad;
    logic          csum_good;
    logic          ok_evt;
    logic          err_evt;
    logic          pop;

    // Reader side only sees committed entries; outputs read 0 while empty.
    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_valid = (rd_ptr != commit_ptr);
    assign out_data  = out_valid ? head[7:0] : '0;
    assign out_last  = out_valid & head[8];
    assign pop       = out_valid & out_ready;

    // Length legality and free-space check; space is measured against
    // commit_ptr so a pending frame can never overrun unread data.
    always_comb begin
        used       = commit_ptr - rd_ptr;
        free_space = PW'(DEPTH) - used;
        len_bad    = (data_in == 8'd0)
                   || (32'(data_in) > 32'(MAX_LEN))
                   || (32'(data_in) > 32'(free_space));
        csum_good  = (data_in == csum_acc);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and frame-decision events; valid_in=0 holds the FSM.
    always_comb begin
        state_nx = state;
        ok_evt   = 1'b0;
        err_evt  = 1'b0;
        if (valid_in) begin
            case (state)
                IDLE: begin
                    if (data_in == SOF) state_nx = LEN;
                end
                LEN: begin
                    if (len_bad) begin
                        err_evt  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (rem == 8'd1) state_nx = CSUM;
                end
                CSUM: begin
                    ok_evt   = csum_good;
                    err_evt  = ~csum_good;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Pointers, checksum accumulator, pulses and saturating error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            csum_acc   <= '0;
            rem        <= '0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= '0;
        end else begin
            frame_ok  <= ok_evt;
            frame_err <= err_evt;
            if (err_evt && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (valid_in) begin
                case (state)
                    LEN: begin
                        if (!len_bad) begin
                            csum_acc <= data_in;
                            rem      <= data_in;
                        end
                    end
                    PAYLOAD: begin
                        wr_ptr   <= wr_ptr + 1'b1;
                        csum_acc <= csum_acc ^ data_in;
                        rem      <= rem - 8'd1;
                    end
                    CSUM: begin
                        if (csum_good) commit_ptr <= wr_ptr;
                        else           wr_ptr     <= commit_ptr;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Payload storage: {last, byte}; contents need no reset.
    always_ff @(posedge clk) begin
        if (valid_in && (state == PAYLOAD)) begin
            mem[wr_ptr[AW-1:0]] <= {(rem == 8'd1), data_in};
        end
    end

endmodule

// File: tb/tb_starter_frame_rx.sv
// Testbench for starter_frame_rx: scoreboard of committed payload bytes,
// one task per scenario.
module tb_starter_frame_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       valid_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic [7:0] err_count;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         ok_seen  = 0;
    int         err_seen = 0;
    int         exp_err  = 0;
    logic [8:0] sb [$];
    logic [8:0] mon_exp;
    logic [7:0] pay [$];

    starter_frame_rx #(.DEPTH(16), .MAX_LEN(16), .SOF(8'hA5)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .frame_ok(frame_ok), .frame_err(frame_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Monitor: counts pulses, compares every popped byte with the scoreboard.
    always @(negedge clk) begin
        if (frame_ok === 1'b1) ok_seen++;
        if (frame_err === 1'b1) err_seen++;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got last=%b data=%h, required no output", out_last, out_data);
            end else begin
                mon_exp = sb.pop_front();
                if ({out_last, out_data} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL pop_data: got last=%b data=%h, required last=%b data=%h",
                             out_last, out_data, mon_exp[8], mon_exp[7:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_in  = b;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        data_in  = 8'h00;
    endtask

    // Sends A5, len, pay[], checksum^csum_flip; pushes payload if commit.
    task automatic send_frame(input logic [7:0] csum_flip, input bit commit, input int gap);
        logic [7:0] c;
        logic [7:0] len;
        len = 8'(pay.size());
        c   = len;
        for (int i = 0; i < pay.size(); i++) begin
            c = c ^ pay[i];
            if (commit) sb.push_back({(i == pay.size() - 1), pay[i]});
        end
        send_byte(8'hA5);
        if (gap > 0) idle($urandom_range(0, gap));
        send_byte(len);
        for (int i = 0; i < pay.size(); i++) begin
            if (gap > 0) idle($urandom_range(0, gap));
            send_byte(pay[i]);
        end
        if (gap > 0) idle($urandom_range(0, gap));
        send_byte(c ^ csum_flip);
    endtask

    task automatic wait_drain(input string tag);
        int cyc;
        cyc = 0;
        while ((sb.size() != 0 || out_valid !== 1'b0) && cyc < 200) begin
            idle(1);
            cyc++;
        end
        n_checks++;
        if (cyc >= 200) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d bytes left, required 0 within 200 cycles", tag, sb.size());
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        valid_in  = 1'b0;
        data_in   = 8'h00;
        out_ready = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_data, out_last, frame_ok, frame_err, err_count} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b ok=%b err=%b cnt=%h, required all 0",
                     out_valid, out_data, out_last, frame_ok, frame_err, err_count);
        end
        idle(3);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_good_frame();
        int ok0;
        ok0       = ok_seen;
        out_ready = 1'b1;
        pay       = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h00, 1'b1, 0);
        n_checks++;
        if ({frame_ok, out_valid, out_last, out_data} !== {1'b1, 1'b1, 1'b0, 8'h11}) begin
            n_fail++;
            $display("FAIL t1_commit: got ok=%b v=%b l=%b d=%h, required ok=1 v=1 l=0 d=11",
                     frame_ok, out_valid, out_last, out_data);
        end
        wait_drain("t1");
        n_checks++;
        if (ok_seen - ok0 != 1) begin
            n_fail++;
            $display("FAIL t1_ok_pulses: got %0d, required 1", ok_seen - ok0);
        end
    endtask

    task automatic test_bad_csum();
        int err0;
        err0 = err_seen;
        pay  = '{8'h10, 8'h20};
        send_frame(8'h32, 1'b0, 0);
        exp_err++;
        n_checks++;
        if ({frame_err, frame_ok, err_count} !== {1'b1, 1'b0, 8'(exp_err)}) begin
            n_fail++;
            $display("FAIL t2_bad_csum: got err=%b ok=%b cnt=%0d, required err=1 ok=0 cnt=%0d",
                     frame_err, frame_ok, err_count, exp_err);
        end
        idle(3);
        n_checks++;
        if (out_valid !== 1'b0 || err_seen - err0 != 1) begin
            n_fail++;
            $display("FAIL t2_discard: got v=%b err_pulses=%0d, required v=0 err_pulses=1",
                     out_valid, err_seen - err0);
        end
    endtask

    task automatic test_bad_len();
        send_byte(8'hA5);
        send_byte(8'h00);
        exp_err++;
        n_checks++;
        if (frame_err !== 1'b1 || err_count !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL t3_len_zero: got err=%b cnt=%0d, required err=1 cnt=%0d", frame_err, err_count, exp_err);
        end
        send_byte(8'hA5);
        send_byte(8'h11);
        exp_err++;
        n_checks++;
        if (frame_err !== 1'b1 || err_count !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL t3_len_big: got err=%b cnt=%0d, required err=1 cnt=%0d", frame_err, err_count, exp_err);
        end
        pay = '{8'h7E};
        send_frame(8'h00, 1'b1, 0);
        n_checks++;
        if ({frame_ok, out_valid, out_last, out_data} !== {1'b1, 1'b1, 1'b1, 8'h7E}) begin
            n_fail++;
            $display("FAIL t3_recover: got ok=%b v=%b l=%b d=%h, required ok=1 v=1 l=1 d=7e",
                     frame_ok, out_valid, out_last, out_data);
        end
        wait_drain("t3");
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        pay.delete();
        for (int i = 0; i < 16; i++) pay.push_back(8'(i * 13 + 5));
        send_frame(8'h00, 1'b1, 0);
        send_byte(8'hA5);
        send_byte(8'h01);
        exp_err++;
        n_checks++;
        if (frame_err !== 1'b1 || err_count !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL t4_no_space: got err=%b cnt=%0d, required err=1 cnt=%0d", frame_err, err_count, exp_err);
        end
        send_byte(8'h55);
        send_byte(8'h54);
        idle(2);
        n_checks++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 8'h05} || err_count !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL t4_hold: got v=%b l=%b d=%h cnt=%0d, required v=1 l=0 d=05 cnt=%0d",
                     out_valid, out_last, out_data, err_count, exp_err);
        end
        out_ready = 1'b1;
        wait_drain("t4");
    endtask

    task automatic test_back_to_back();
        int ok0;
        ok0 = ok_seen;
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    pay.delete();
                    for (int i = 0; i < int'($urandom_range(1, 5)); i++) pay.push_back(8'($urandom));
                    send_frame(8'h00, 1'b1, 2);
                end
            end
            begin
                repeat (120) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("t5");
        n_checks++;
        if (ok_seen - ok0 != 3 || err_count !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL t5_frames: got ok_pulses=%0d cnt=%0d, required ok_pulses=3 cnt=%0d",
                     ok_seen - ok0, err_count, exp_err);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h11);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, out_data, out_last, frame_ok, frame_err, err_count} !== 19'd0) begin
            n_fail++;
            $display("FAIL t6_reset: got v=%b d=%h l=%b ok=%b err=%b cnt=%h, required all 0",
                     out_valid, out_data, out_last, frame_ok, frame_err, err_count);
        end
        idle(2);
        rst     = 1'b0;
        exp_err = 0;
        idle(1);
        pay = '{8'h09};
        send_frame(8'h00, 1'b1, 0);
        n_checks++;
        if ({frame_ok, out_valid, out_last, out_data, err_count} !== {1'b1, 1'b1, 1'b1, 8'h09, 8'h00}) begin
            n_fail++;
            $display("FAIL t6_after: got ok=%b v=%b l=%b d=%h cnt=%0d, required ok=1 v=1 l=1 d=09 cnt=0",
                     frame_ok, out_valid, out_last, out_data, err_count);
        end
        wait_drain("t6");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_bad_len();
        test_full();
        test_back_to_back();
        test_mid_reset();
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
